// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath enables plus the 4-bit ALU op; outputs decode from the state register.
module mips_mc_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b0111;
    localparam logic [3:0] ALU_SLT = 4'b1010;

    state_t     state;
    state_t     next_state;
    state_t     cur;
    logic       funct_ok;
    logic [3:0] funct_alu_op;
    logic       decode_illegal;

    always_comb begin
        funct_ok     = 1'b1;
        funct_alu_op = ALU_ADD;
        case (funct)
            6'b100000: funct_alu_op = ALU_ADD;
            6'b100010: funct_alu_op = ALU_SUB;
            6'b100100: funct_alu_op = ALU_AND;
            6'b100101: funct_alu_op = ALU_OR;
            6'b100110: funct_alu_op = ALU_XOR;
            6'b100111: funct_alu_op = ALU_NOR;
            6'b101010: funct_alu_op = ALU_SLT;
            default:   funct_ok     = 1'b0;
        endcase
    end

    always_comb begin
        decode_illegal = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: decode_illegal = 1'b0;
            OP_RTYPE:                            decode_illegal = !funct_ok;
            default:                             decode_illegal = 1'b1;
        endcase
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYPE:     next_state = funct_ok ? EXECUTE : FETCH;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDIEXEC;
                    OP_J:         next_state = JUMP;
                    default:      next_state = FETCH;
                endcase
            end
            // IR is stable across the instruction, so opcode still selects lw vs sw here
            MEMADR:   next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    next_state = mem_ready ? MEMWB : MEMRD;
            MEMWB:    next_state = FETCH;
            MEMWR:    next_state = mem_ready ? FETCH : MEMWR;
            EXECUTE:  next_state = ALUWB;
            ALUWB:    next_state = FETCH;
            BRANCH:   next_state = FETCH;
            ADDIEXEC: next_state = ADDIWB;
            ADDIWB:   next_state = FETCH;
            JUMP:     next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= state_t'(RESET_STATE);
        end else begin
            state <= next_state;
        end
    end

    // While reset is held the datapath sees FETCH controls, whatever the register holds
    assign cur       = reset_n ? state : FETCH;
    assign state_dbg = state;

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = ALU_ADD;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        case (cur)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                illegal   = decode_illegal;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = funct_alu_op;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = zero;
            end
            ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
Multicycle MIPS control unit: the instruction-side initiator that drives the ALU operation code and all datapath enables.
- Sequences fetch, decode, execute, memory and writeback over several clocks per instruction.
- Decodes opcode/funct from the instruction register into the team's 4-bit ALU op encoding.
- Sits between instruction register, memory interface and datapath muxes/ALU.

Parameters:
- RESET_STATE, 4'd0, state encoding loaded on reset (FETCH); must not be changed from 0 in the core.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous active-low reset
- opcode  in  6  instruction bits [31:26] from IR
- funct  in  6  instruction bits [5:0] from IR
- zero  in  1  ALU result-is-zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  access is a write
- iord  out  1  0 = PC address, 1 = ALU-out address
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  2  00 ALU result, 01 ALU-out register, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  4  0000 add, 0010 sub, 0100 and, 0101 or, 0110 xor, 0111 nor, 1010 slt
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALU-out, 1 = memory data
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse on unsupported instruction
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: reset_n=0 at a rising clk edge sets state = FETCH (0), including mid-instruction. No other state survives reset.
- Outputs are Moore, decoded combinationally from state, except:
  - FETCH ir_write and pc_write, gated by mem_ready.
  - BRANCH pc_write, gated by zero.
  - EXECUTE alu_op, taken from funct.
- Every output not listed for a state is 0, and alu_op is 0000 unless listed.
- Outputs while reset_n=0 are the FETCH outputs.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
- States, outputs and next state:
  - FETCH: mem_req=1, alu_src_b=01, add; ir_write=pc_write=mem_ready. Goes to DECODE when mem_ready=1, else holds.
  - DECODE: alu_src_b=11, add (branch target). Next state by opcode:
    - 100011 lw or 101011 sw -> MEMADR
    - 000000 R-type -> EXECUTE if funct is supported, else illegal=1 and -> FETCH
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEXEC
    - 000010 j -> JUMP
    - any other opcode -> illegal=1, -> FETCH
  - MEMADR: alu_src_a=1, alu_src_b=10, add. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_req=1, iord=1. Holds until mem_ready, then -> MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1. -> FETCH.
  - MEMWR: mem_req=1, mem_write=1, iord=1. Holds until mem_ready, then -> FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00. alu_op from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt. -> ALUWB.
  - ALUWB: reg_dst=1, reg_write=1. -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_write=zero. -> FETCH.
  - ADDIEXEC: alu_src_a=1, alu_src_b=10, add. -> ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0. -> FETCH.
  - JUMP: pc_src=10, pc_write=1. -> FETCH.
- Latency with mem_ready held high:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Illegal instruction: the PC has already advanced in FETCH, so execution continues at PC+4. No register or memory write occurs.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Unused state encodings 12-15 -> FETCH next cycle with all outputs 0.

Test Plan:
- Reset then mem_ready=1, IR opcode 000000 funct 101010 -> state sequence 0,1,6,7,0; alu_op=1010 in state 6; reg_write=1, reg_dst=1 in state 7.
- lw (100011), mem_ready low for 2 cycles in MEMRD -> 0,1,2,3,3,3,4,0; iord=1 and mem_req=1 throughout state 3; mem_to_reg=1 and reg_write=1 in state 4.
- beq with zero=1, then beq with zero=0 -> pc_write=1 / 0 in state 8; alu_op=0010 and pc_src=01 both times.
- opcode 111111, then R-type funct 000000 -> illegal=1 for one cycle in DECODE; next state FETCH; no reg_write or mem_write asserted.
- FETCH with mem_ready=0 for 3 cycles -> stays in state 0; ir_write=pc_write=0 until the ready cycle, then both 1 for exactly one cycle.
- reset_n=0 in MEMWR with mem_req=1 -> next state 0; mem_write=0 the cycle after the reset edge.
